ex_mem_stage: RTL and testbench

Pipeline boundary between the Execution stage and the Memory stage. It captures ALU result, zero flag, overflow flag, destination register and memory/writeback control bits with a valid/ready handshake. It converts an ALU overflow on a trapping instruction into a precise exception: the faulting instruction's register write and memory access are suppressed, and its PC is held for the exception logic. It also provides the EX/MEM forwarding source for the Decode stage.

---
 rtl/ex_mem_stage.sv | 137 +++++++++++++
 tb/tb_ex_mem_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, precise overflow trap
// capture and the EX/MEM forwarding source for the Decode stage.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_ALUresult,
    input  logic              ex_zeroflag,
    input  logic              ex_overFlow,
    input  logic [REG_W-1:0]  ex_WriteReg,
    input  logic [DATA_W-1:0] ex_StoreData,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic              ex_RegWrite,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_MemToReg,
    input  logic              ex_TrapOvf,
    input  logic              flush,
    input  logic              mem_ready,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_ALUresult,
    output logic [DATA_W-1:0] mem_StoreData,
    output logic              mem_zeroflag,
    output logic [REG_W-1:0]  mem_WriteReg,
    output logic              mem_RegWrite,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic              mem_MemToReg,
    output logic              fwd_en,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              exc_valid,
    output logic [DATA_W-1:0] exc_epc,
    input  logic              exc_ack
);

    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic              zf;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] sdata;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
    } ex_mem_t;

    state_t  state, state_nxt;
    ex_mem_t held, incoming;
    logic    accept, trap_take;

    assign ex_ready  = (state == RUN) & (!mem_valid | mem_ready);
    assign accept    = ex_valid & ex_ready & !flush;
    assign trap_take = accept & ex_overFlow & ex_TrapOvf;

    // A trapping instruction still occupies the slot, but as a bubble with
    // no architectural side effects.
    always_comb begin
        incoming.alu      = ex_ALUresult;
        incoming.zf       = ex_zeroflag;
        incoming.wreg     = ex_WriteReg;
        incoming.sdata    = ex_StoreData;
        incoming.regwrite = ex_RegWrite & !trap_take;
        incoming.memread  = ex_MemRead  & !trap_take;
        incoming.memwrite = ex_MemWrite & !trap_take;
        incoming.memtoreg = ex_MemToReg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN) begin
            if (trap_take)
                state_nxt = TRAP;
        end else begin
            if (exc_ack)
                state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_valid <= 1'b0;
        else if (flush)
            mem_valid <= 1'b0;
        else if (accept)
            mem_valid <= 1'b1;
        else if (mem_ready)
            mem_valid <= 1'b0;
    end

    // Payload only moves on accept; a drain leaves the last values visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            held <= '0;
        else if (accept)
            held <= incoming;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_valid <= 1'b0;
            exc_epc   <= '0;
        end else if (trap_take) begin
            exc_valid <= 1'b1;
            exc_epc   <= ex_pc;
        end else if (state == TRAP && exc_ack) begin
            exc_valid <= 1'b0;
        end
    end

    assign mem_ALUresult = held.alu;
    assign mem_StoreData = held.sdata;
    assign mem_zeroflag  = held.zf;
    assign mem_WriteReg  = held.wreg;
    assign mem_RegWrite  = held.regwrite;
    assign mem_MemRead   = held.memread;
    assign mem_MemWrite  = held.memwrite;
    assign mem_MemToReg  = held.memtoreg;

    assign fwd_en   = mem_valid & held.regwrite & (held.wreg != '0);
    assign fwd_reg  = held.wreg;
    assign fwd_data = held.alu;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed + randomized bench for ex_mem_stage against a behavioural model.
module tb_ex_mem_stage;

    logic        clk, rst_n;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_ALUresult, ex_StoreData, ex_pc;
    logic        ex_zeroflag, ex_overFlow, ex_TrapOvf;
    logic [4:0]  ex_WriteReg;
    logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg;
    logic        flush, mem_ready, exc_ack;
    logic        mem_valid;
    logic [31:0] mem_ALUresult, mem_StoreData;
    logic        mem_zeroflag;
    logic [4:0]  mem_WriteReg;
    logic        mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemToReg;
    logic        fwd_en;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        exc_valid;
    logic [31:0] exc_epc;

    int n_cmp = 0;
    int n_bad = 0;

    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_ALUresult(ex_ALUresult), .ex_zeroflag(ex_zeroflag),
        .ex_overFlow(ex_overFlow), .ex_WriteReg(ex_WriteReg),
        .ex_StoreData(ex_StoreData), .ex_pc(ex_pc),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg),
        .ex_TrapOvf(ex_TrapOvf), .flush(flush), .mem_ready(mem_ready),
        .mem_valid(mem_valid), .mem_ALUresult(mem_ALUresult),
        .mem_StoreData(mem_StoreData), .mem_zeroflag(mem_zeroflag),
        .mem_WriteReg(mem_WriteReg), .mem_RegWrite(mem_RegWrite),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_MemToReg(mem_MemToReg), .fwd_en(fwd_en), .fwd_reg(fwd_reg),
        .fwd_data(fwd_data), .exc_valid(exc_valid), .exc_epc(exc_epc),
        .exc_ack(exc_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction currently held plus exception status.
    typedef struct {
        logic [31:0] alu, sd;
        logic        zf;
        logic [4:0]  wr;
        logic        rw, mr, mw, m2r;
    } ent_t;

    ent_t        m_last;
    bit          m_valid, m_trap, m_excv;
    logic [31:0] m_epc;

    function automatic void model_reset();
        m_last = '{alu: 0, sd: 0, zf: 0, wr: 0, rw: 0, mr: 0, mw: 0, m2r: 0};
        m_valid = 0; m_trap = 0; m_excv = 0; m_epc = 0;
    endfunction

    function automatic bit model_ready();
        return !m_trap && (!m_valid || mem_ready);
    endfunction

    function automatic void model_edge();
        bit was_trap = m_trap;
        bit take = ex_valid && model_ready() && !flush;
        if (flush) begin
            m_valid = 0;
        end else if (take) begin
            m_last.alu = ex_ALUresult; m_last.sd = ex_StoreData;
            m_last.zf = ex_zeroflag;   m_last.wr = ex_WriteReg;
            m_last.rw = ex_RegWrite;   m_last.mr = ex_MemRead;
            m_last.mw = ex_MemWrite;   m_last.m2r = ex_MemToReg;
            if (ex_overFlow && ex_TrapOvf) begin
                m_last.rw = 0; m_last.mr = 0; m_last.mw = 0;
                m_trap = 1; m_excv = 1; m_epc = ex_pc;
            end
            m_valid = 1;
        end else if (mem_ready) begin
            m_valid = 0;
        end
        if (was_trap && exc_ack) begin
            m_trap = 0; m_excv = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("mem_valid", {31'b0, mem_valid}, {31'b0, m_valid});
        chk("mem_ALUresult", mem_ALUresult, m_last.alu);
        chk("mem_StoreData", mem_StoreData, m_last.sd);
        chk("mem_zeroflag", {31'b0, mem_zeroflag}, {31'b0, m_last.zf});
        chk("mem_WriteReg", {27'b0, mem_WriteReg}, {27'b0, m_last.wr});
        chk("mem_ctl", {28'b0, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemToReg},
            {28'b0, m_last.rw, m_last.mr, m_last.mw, m_last.m2r});
        chk("fwd_en", {31'b0, fwd_en}, {31'b0, m_valid && m_last.rw && m_last.wr != 0});
        chk("fwd_reg", {27'b0, fwd_reg}, {27'b0, m_last.wr});
        chk("fwd_data", fwd_data, m_last.alu);
        chk("exc_valid", {31'b0, exc_valid}, {31'b0, m_excv});
        chk("exc_epc", exc_epc, m_epc);
    endtask

    // Check ex_ready before the edge, advance one edge, check all outputs.
    task automatic tick();
        #1;
        chk("ex_ready", {31'b0, ex_ready}, {31'b0, model_ready()});
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_ins(input logic v, input logic [31:0] alu, input logic ovf,
                           input logic tov, input logic rw, input logic [4:0] wr,
                           input logic [31:0] pc);
        ex_valid = v; ex_ALUresult = alu; ex_overFlow = ovf; ex_TrapOvf = tov;
        ex_RegWrite = rw; ex_WriteReg = wr; ex_pc = pc;
        ex_zeroflag = (alu == 0);
        ex_StoreData = $urandom;
        ex_MemRead = 1'($urandom); ex_MemWrite = 1'($urandom); ex_MemToReg = 1'($urandom);
    endtask

    initial begin
        rst_n = 0; flush = 0; mem_ready = 0; exc_ack = 0;
        set_ins(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all();
        rst_n = 1;

        // Streaming
        mem_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            set_ins(1, i, 0, 0, 1, 5'd3, 32'h0040_0000 + 4 * i);
            tick();
            chk("stream_result", mem_ALUresult, i);
        end
        ex_valid = 0; tick();

        // Stall
        set_ins(1, 32'hDEAD_BEEF, 0, 0, 1, 5'd9, 32'h0040_0100);
        tick();
        mem_ready = 0;
        set_ins(1, 32'h0000_0011, 0, 0, 1, 5'd10, 32'h0040_0104);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", mem_ALUresult, 32'hDEAD_BEEF);
        end
        mem_ready = 1; tick();
        chk("stall_release", mem_ALUresult, 32'h0000_0011);
        ex_valid = 0; tick();

        // Overflow trap
        set_ins(1, 32'h8000_0000, 1, 1, 1, 5'd7, 32'h0040_0010);
        tick();
        chk("trap_epc", exc_epc, 32'h0040_0010);
        chk("trap_excv", {31'b0, exc_valid}, 32'd1);
        chk("trap_rw", {31'b0, mem_RegWrite}, 32'd0);
        chk("trap_fwd", {31'b0, fwd_en}, 32'd0);
        set_ins(1, 32'h0000_0022, 0, 0, 1, 5'd4, 32'h0040_0014);
        tick(); tick();
        exc_ack = 1; tick();
        exc_ack = 0; tick();
        chk("post_ack_accept", mem_ALUresult, 32'h0000_0022);

        // Non-trapping overflow
        set_ins(1, 32'h8000_0000, 1, 0, 1, 5'd7, 32'h0040_0010);
        tick();
        chk("nontrap_rw", {31'b0, mem_RegWrite}, 32'd1);
        chk("nontrap_excv", {31'b0, exc_valid}, 32'd0);

        // Flush beats a trapping accept
        set_ins(1, 32'h8000_0000, 1, 1, 1, 5'd7, 32'h0040_0020);
        flush = 1; tick(); flush = 0;
        chk("flush_valid", {31'b0, mem_valid}, 32'd0);
        chk("flush_excv", {31'b0, exc_valid}, 32'd0);

        // r0 is never a forwarding source
        set_ins(1, 32'h1234_5678, 0, 0, 1, 5'd0, 32'h0040_0030);
        tick();
        chk("fwd_r0", {31'b0, fwd_en}, 32'd0);

        // Async reset while trapped with a stalled entry
        mem_ready = 0;
        set_ins(1, 32'h8000_0000, 1, 1, 1, 5'd8, 32'h0040_0040);
        tick();
        ex_valid = 0;
        #2 rst_n = 0;
        #1 model_reset();
        check_all();
        #2 rst_n = 1;
        #1 chk("reset_ready", {31'b0, ex_ready}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_ins(($urandom % 4) != 0, $urandom, ($urandom % 4) == 0, 1'($urandom),
                    1'($urandom), 5'($urandom), $urandom);
            mem_ready = ($urandom % 4) != 0;
            flush = ($urandom % 16) == 0;
            exc_ack = m_trap ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
